// File: rtl/bus_writer.sv
// Queued register-bus writer: a 4-entry request FIFO feeds an ADDR/DATA/STROBE/HOLD sequencer.
// Optional acknowledge wait with timeout is enabled by defining BUS_WRITER_ACK_WAIT_EN.
module bus_writer #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic       en_sig,
    input  logic       ack,
    output logic       busy,
    output logic       err
);

    localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_B = (HOLD_CYC > ACK_TIMEOUT) ? HOLD_CYC : ACK_TIMEOUT;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXP + 2);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STROBE,
`ifdef BUS_WRITER_ACK_WAIT_EN
        ACKW,
`endif
        HOLD
    } state_t;

    // Request FIFO: 3-bit pointers, the MSB distinguishes full from empty.
    logic [15:0]   mem [4];
    logic [2:0]    wr_ptr_reg;
    logic [2:0]    rd_ptr_reg;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [7:0]    addr_reg;
    logic [7:0]    data_reg;
    logic [7:0]    cur_data_reg;
    logic          en_reg;
    logic          err_set;

    assign full     = (wr_ptr_reg[1:0] == rd_ptr_reg[1:0]) && (wr_ptr_reg[2] != rd_ptr_reg[2]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign push     = wr_req && !full;
    assign head     = mem[rd_ptr_reg[1:0]];
    assign wr_ready = !full;
    assign busy     = (state_reg != IDLE) || !empty;
    assign addr     = addr_reg;
    assign data     = data_reg;
    assign en_sig   = en_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[1:0]] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        pop        = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (cnt_reg == CW'(SETUP_CYC - 1)) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                state_next = STROBE;
                cnt_next   = '0;
            end
            STROBE: begin
                if (cnt_reg == CW'(STROBE_CYC - 1)) begin
`ifdef BUS_WRITER_ACK_WAIT_EN
                    state_next = ACKW;
`else
                    state_next = HOLD;
`endif
                    cnt_next   = '0;
                end
            end
`ifdef BUS_WRITER_ACK_WAIT_EN
            ACKW: begin
                if (ack) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    err_set    = 1'b1;
                end
            end
`endif
            HOLD: begin
                if (cnt_reg == CW'(HOLD_CYC - 1)) begin
                    cnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ADDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            cur_data_reg <= '0;
            en_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (pop) begin
                addr_reg     <= head[15:8];
                cur_data_reg <= head[7:0];
            end
            if (state_reg == ADDR && state_next == DATA) begin
                data_reg <= cur_data_reg;
            end
`ifdef BUS_WRITER_ACK_WAIT_EN
            en_reg <= (state_next == STROBE) || (state_next == ACKW);
`else
            en_reg <= (state_next == STROBE);
`endif
        end
    end

`ifdef BUS_WRITER_ACK_WAIT_EN
    logic err_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    logic unused_ack;
    logic unused_err_set;
    assign unused_ack     = ack;
    assign unused_err_set = err_set;
    assign err            = 1'b0;
`endif

endmodule
